// File: rtl/mux_pkg.sv
// Shared sizing and types for the round-robin mux4 arbiter slice.
//   N_SRC : number of arbitrated sources
//   SEL_W : width of a source index
//   sel_t : source index type (priority pointer, select, grant index)
package mux_pkg;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux4.sv
// Four-way data word selector.
//   d0..d3 : candidate words
//   sel    : index of the word forwarded
//   y      : selected word
module mux4
    import mux_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  sel_t         sel,
    output logic [W-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick among four requesters.
//   req : request vector
//   ptr : index searched first; search continues ptr+1, ptr+2, ptr+3 (mod 4)
//   gnt : one-hot grant, zero when no request
//   idx : encoded index of the granted requester
//   any : at least one request present
module rr_pick4
    import mux_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  sel_t             ptr,
    output logic [N_SRC-1:0] gnt,
    output sel_t             idx,
    output logic             any
);

    logic [2*N_SRC-1:0] req2_c;
    logic [N_SRC-1:0]   rot_c;
    sel_t               off_c;

    // Rotate so ptr lands at bit 0, fixed-priority pick, rotate the index back.
    always_comb begin
        req2_c = {req, req};
        rot_c  = N_SRC'(req2_c >> ptr);
        off_c  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot_c[i]) begin
                off_c = SEL_W'(i);
            end
        end
        any = |req;
        idx = ptr + off_c;
        gnt = any ? (N_SRC'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_mux4_arb.sv
// Four-source round-robin arbiter with a one-entry registered output stage.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid[3:0]  : per-source word present on d0..d3
//   d0..d3         : source words
//   in_ready[3:0]  : per-source accept (one-hot or zero, combinational)
//   out_valid      : output register holds a word
//   out_data       : registered word
//   out_sel        : source index of out_data
//   out_ready      : downstream takes out_data this cycle
module rr_mux4_arb
    import mux_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] in_valid,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [N_SRC-1:0] in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output sel_t             out_sel,
    input  logic             out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    sel_t             out_sel_q, out_sel_d;
    sel_t             ptr_q, ptr_d;

    logic [N_SRC-1:0] gnt_c;
    sel_t             idx_c;
    logic             any_c;
    logic [W-1:0]     pick_data_c;
    logic             load_en_c;
    logic             xfer_c;

    rr_pick4 u_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .gnt (gnt_c),
        .idx (idx_c),
        .any (any_c)
    );

    mux4 #(.W(W)) u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .sel (idx_c),
        .y   (pick_data_c)
    );

    // Output register load/drain and pointer advance.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;

        load_en_c = ~out_valid_q | out_ready;
        // Held at zero during reset so no handshake is reported while rst_n is low.
        in_ready  = gnt_c & {N_SRC{load_en_c & rst_n}};
        xfer_c    = any_c & load_en_c;

        if (xfer_c) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_data_c;
            out_sel_d   = idx_c;
            ptr_d       = idx_c + SEL_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux4_arb.sv
// Self-checking bench for rr_mux4_arb: reference model + scoreboard of accepted words.
module tb_rr_mux4_arb;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [W-1:0] d [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    exp_t         sbq [$];
    logic         mvalid;
    logic [1:0]   mptr;
    logic [1:0]   msel;
    logic [W-1:0] mdata;

    rr_mux4_arb #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mvalid = 1'b0;
        mptr   = 2'd0;
        msel   = 2'd0;
        mdata  = '0;
        sbq.delete();
    endtask

    // Check at the falling edge, advance the model, then return just after the rising edge.
    task automatic step();
        logic       load;
        logic       found;
        logic [1:0] gi;
        logic [1:0] c;
        logic [3:0] er;
        exp_t       e;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_ready", 32'(in_ready), 0);
            chk("rst_sel", 32'(out_sel), 0);
            model_reset();
        end else begin
            load  = !mvalid || out_ready;
            found = 1'b0;
            gi    = 2'd0;
            for (int k = 0; k < 4; k++) begin
                c = 2'(mptr + 2'(k));
                if (!found && in_valid[c]) begin
                    found = 1'b1;
                    gi    = c;
                end
            end
            er = (found && load) ? (4'b0001 << gi) : 4'b0000;
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("out_valid", 32'(out_valid), 32'(mvalid));
            chk("ptr", 32'(dut.ptr_q), 32'(mptr));
            chk("out_data", 32'(out_data), 32'(mdata));
            chk("out_sel", 32'(out_sel), 32'(msel));
            if (out_valid && out_ready) begin
                chk("sb_depth", 32'(sbq.size()), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.data));
                    chk("sb_sel", 32'(out_sel), 32'(e.sel));
                end
            end
            if (found && load) begin
                e.sel  = gi;
                e.data = d[gi];
                sbq.push_back(e);
                mptr   = 2'(gi + 2'd1);
                mvalid = 1'b1;
                mdata  = d[gi];
                msel   = gi;
            end else if (mvalid && out_ready) begin
                mvalid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [1:0] skip_seq [4];

    initial begin
        skip_seq[0] = 2'd3; skip_seq[1] = 2'd1; skip_seq[2] = 2'd3; skip_seq[3] = 2'd1;
        model_reset();

        // Reset held with all sources valid and downstream ready.
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h3; d[3] = 4'h4;
        step();
        step();
        rst_n = 1'b1;

        // Round-robin rotation at full throughput.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rot_sel", 32'(out_sel), 32'(k % 4));
            chk("rot_data", 32'(out_data), 32'(k % 4 + 1));
        end

        // Move ptr to 2, then only sources 1 and 3 valid.
        in_valid = 4'b0010; d[1] = 4'h5;
        step();
        chk("skip_pre_ptr", 32'(dut.ptr_q), 2);
        in_valid = 4'b1010; d[1] = 4'h6; d[3] = 4'h7;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("skip_sel", 32'(out_sel), 32'(skip_seq[k]));
            if (k == 0) chk("skip_ptr_wrap", 32'(dut.ptr_q), 0);
        end

        // Backpressure with a word from source 2.
        in_valid = 4'b0100; d[2] = 4'hA;
        step();
        in_valid = 4'b1111; out_ready = 1'b0;
        d[0] = 4'h8; d[1] = 4'h9; d[2] = 4'hC; d[3] = 4'hD;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_data", 32'(out_data), 32'hA);
            chk("bp_sel", 32'(out_sel), 2);
            chk("bp_ready", 32'(in_ready), 0);
            chk("bp_ptr", 32'(dut.ptr_q), 3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_grant", 32'(in_ready), 32'h8);
        step();
        chk("bp_next_sel", 32'(out_sel), 3);
        chk("bp_next_data", 32'(out_data), 32'hD);

        // Drain to empty, then idle.
        in_valid = 4'b0000;
        step();
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_data", 32'(out_data), 32'hD);
        for (int k = 0; k < 3; k++) step();
        chk("idle_ptr", 32'(dut.ptr_q), 0);

        // Asynchronous reset while stalled.
        in_valid = 4'b0010; d[1] = 4'hE; out_ready = 1'b0;
        step();
        in_valid = 4'b0000;
        step();
        chk("arst_pre_valid", 32'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_ptr", 32'(dut.ptr_q), 0);
        chk("arst_ready", 32'(in_ready), 0);
        step();
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        d[0] = 4'h3; d[1] = 4'h4; d[2] = 4'h5; d[3] = 4'h6;
        step();
        chk("arst_first_sel", 32'(out_sel), 0);
        chk("arst_first_data", 32'(out_data), 3);

        // Randomised traffic against the model.
        for (int k = 0; k < 60; k++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 4; j++) d[j] = W'($urandom_range(0, 15));
            step();
        end

        in_valid  = 4'b0000;
        out_ready = 1'b1;
        step();
        step();
        chk("sb_final", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
